// File: rtl/sipo_word_deserializer_pkg.sv
// Shared constants for the serial word deserializer: default word size and
// bit-order encodings used by the LSB_FIRST parameter.
package sipo_word_deserializer_pkg;

    localparam int SCI_DEFAULT_DEPTH = 8;

    localparam bit SCI_LSB_FIRST = 1'b1;
    localparam bit SCI_MSB_FIRST = 1'b0;

endpackage

// File: rtl/sipo_word_deserializer_if.sv
// Serial input / held parallel output bundle of the deserializer.
// The slave modport is the deserializer side, the master modport is the
// serial front-end plus the consumer of the parallel word.
interface sipo_word_deserializer_if
    import sipo_word_deserializer_pkg::*;
#(
    parameter int DEPTH = SCI_DEFAULT_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH);

    logic             sin;
    logic             en;
    logic             clear;
    logic [DEPTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    modport slave (
        input  sin,
        input  en,
        input  clear,
        input  pout_ready,
        output pout,
        output pout_valid,
        output bit_cnt,
        output overrun
    );

    modport master (
        output sin,
        output en,
        output clear,
        output pout_ready,
        input  pout,
        input  pout_valid,
        input  bit_cnt,
        input  overrun
    );

endinterface

// File: rtl/sipo_word_deserializer_shift_core.sv
// Shift register and bit counter. Raises complete for the cycle in which the
// DEPTH-th bit is accepted; word is the shift value including that bit.
module sipo_word_deserializer_shift_core
    import sipo_word_deserializer_pkg::*;
#(
    parameter int DEPTH     = SCI_DEFAULT_DEPTH,
    parameter bit LSB_FIRST = SCI_LSB_FIRST,
    localparam int CNT_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             complete,
    output logic [DEPTH-1:0] word
);

    logic [DEPTH-1:0] sh;
    logic [DEPTH-1:0] sh_next;
    logic             last_bit;

    generate
        if (LSB_FIRST == SCI_LSB_FIRST) begin : g_lsb_first
            assign sh_next = {sin, sh[DEPTH-1:1]};
        end else begin : g_msb_first
            assign sh_next = {sh[DEPTH-2:0], sin};
        end
    endgenerate

    assign last_bit = (bit_cnt == CNT_W'(DEPTH - 1));
    // CLEAR wins over EN, so a bit arriving with CLEAR can never finish a word.
    assign complete = en && !clear && last_bit;
    assign word     = sh_next;

    // Shift and count accepted bits; wrap the counter on the last bit of a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            sh      <= sh_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_word_deserializer.sv
// Serial-in/parallel-out deserializer with a held, back-pressurable output
// word. A word completing while the previous one is still unconsumed is
// dropped and flagged in the sticky overrun bit.
module sipo_word_deserializer
    import sipo_word_deserializer_pkg::*;
#(
    parameter int DEPTH     = SCI_DEFAULT_DEPTH,
    parameter bit LSB_FIRST = SCI_LSB_FIRST
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sipo_word_deserializer_if.slave     bus
);

    logic             complete;
    logic [DEPTH-1:0] word;
    logic             handshake;

    sipo_word_deserializer_shift_core #(
        .DEPTH     (DEPTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (bus.sin),
        .en       (bus.en),
        .clear    (bus.clear),
        .bit_cnt  (bus.bit_cnt),
        .complete (complete),
        .word     (word)
    );

    assign handshake = bus.pout_valid && bus.pout_ready;

    // Output holding register: load on completion when the slot is free or
    // being consumed this edge (no bubble), otherwise drop and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pout       <= '0;
            bus.pout_valid <= 1'b0;
        end else if (complete && (!bus.pout_valid || bus.pout_ready)) begin
            bus.pout       <= word;
            bus.pout_valid <= 1'b1;
        end else if (!complete && handshake) begin
            bus.pout_valid <= 1'b0;
        end
    end

    // Sticky overrun; CLEAR cannot coincide with a completion, so its
    // priority here never hides a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overrun <= 1'b0;
        end else if (bus.clear) begin
            bus.overrun <= 1'b0;
        end else if (complete && bus.pout_valid && !bus.pout_ready) begin
            bus.overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sipo_word_deserializer.sv
// Bench for the word deserializer: one LSB-first and one MSB-first instance
// fed the same serial stream, checked against directed constants and a
// queue-based reference model.
module tb_sipo_word_deserializer;
    import sipo_word_deserializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin = 1'b0, en = 1'b0, clear = 1'b0, ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // reference model: bits of the partial word in arrival order
    bit         bq[$];
    logic [7:0] m_pout_l = 8'h00, m_pout_m = 8'h00;
    logic       m_valid = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    sipo_word_deserializer_if #(.DEPTH(8)) if_l ();
    sipo_word_deserializer_if #(.DEPTH(8)) if_m ();

    assign if_l.sin = sin;   assign if_m.sin = sin;
    assign if_l.en = en;     assign if_m.en = en;
    assign if_l.clear = clear; assign if_m.clear = clear;
    assign if_l.pout_ready = ready; assign if_m.pout_ready = ready;

    sipo_word_deserializer #(.DEPTH(8), .LSB_FIRST(SCI_LSB_FIRST)) dut_l (
        .clk (clk), .rst_n (rst_n), .bus (if_l.slave));
    sipo_word_deserializer #(.DEPTH(8), .LSB_FIRST(SCI_MSB_FIRST)) dut_m (
        .clk (clk), .rst_n (rst_n), .bus (if_m.slave));

    function automatic logic [7:0] pack_word(input bit lsb);
        logic [7:0] w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bq[i]) w = w + (lsb ? (8'd1 << i) : (8'd1 << (7 - i)));
        end
        return w;
    endfunction

    function automatic void model_reset();
        bq.delete();
        m_pout_l = 8'h00; m_pout_m = 8'h00;
        m_valid = 1'b0; m_ovr = 1'b0;
    endfunction

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic cycle(input logic s, input logic e, input logic c, input logic r);
        logic       comp;
        logic       hs;
        logic [7:0] wl, wm;
        sin = s; en = e; clear = c; ready = r;
        @(posedge clk);
        hs = m_valid && r;
        comp = 1'b0;
        wl = 8'h00; wm = 8'h00;
        if (c) begin
            bq.delete();
        end else if (e) begin
            bq.push_back(s);
            if (bq.size() == 8) begin
                comp = 1'b1;
                wl = pack_word(1'b1);
                wm = pack_word(1'b0);
                bq.delete();
            end
        end
        if (comp) begin
            if (!m_valid || r) begin
                m_pout_l = wl; m_pout_m = wm; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (c) m_ovr = 1'b0;
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = 0; i < 8; i++) cycle(w[i], 1'b1, 1'b0, r);
    endtask

    task automatic test_reset();
        tests++;
        if ({if_l.pout, if_l.pout_valid, if_l.bit_cnt, if_l.overrun} !== 13'h0) begin
            fails++; $display("FAIL reset_state_l: got %h expected 0", {if_l.pout, if_l.pout_valid, if_l.bit_cnt, if_l.overrun});
        end
        tests++;
        if ({if_m.pout, if_m.pout_valid, if_m.bit_cnt, if_m.overrun} !== 13'h0) begin
            fails++; $display("FAIL reset_state_m: got %h expected 0", {if_m.pout, if_m.pout_valid, if_m.bit_cnt, if_m.overrun});
        end
    endtask

    task automatic test_basic_word();
        send_word(8'hA5, 1'b1);
        tests++;
        if (if_l.pout !== 8'hA5 || if_l.pout_valid !== 1'b1 || if_l.bit_cnt !== 3'd0) begin
            fails++; $display("FAIL a5_lsb: got pout=%h v=%b cnt=%0d expected a5 1 0", if_l.pout, if_l.pout_valid, if_l.bit_cnt);
        end
        tests++;
        if (if_m.pout !== 8'hA5) begin
            fails++; $display("FAIL a5_msb_palindrome: got %h expected a5", if_m.pout);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (if_l.pout_valid !== 1'b0 || if_l.pout !== 8'hA5) begin
            fails++; $display("FAIL a5_consumed: got v=%b pout=%h expected 0 a5", if_l.pout_valid, if_l.pout);
        end
    endtask

    task automatic test_bit_order();
        send_word(8'h01, 1'b1);
        tests++;
        if (if_l.pout !== 8'h01) begin
            fails++; $display("FAIL order_lsb: got %h expected 01", if_l.pout);
        end
        tests++;
        if (if_m.pout !== 8'h80) begin
            fails++; $display("FAIL order_msb: got %h expected 80", if_m.pout);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_en_gaps();
        logic [7:0] w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            cycle(w[i], 1'b1, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            if (i < 7) begin
                tests++;
                if (if_l.bit_cnt !== 3'(i + 1)) begin
                    fails++; $display("FAIL gap_cnt: got %0d expected %0d", if_l.bit_cnt, i + 1);
                end
            end
        end
        tests++;
        if (if_l.pout !== 8'h3C || if_m.pout !== 8'h3C) begin
            fails++; $display("FAIL gap_word: got %h/%h expected 3c/3c", if_l.pout, if_m.pout);
        end
    endtask

    task automatic test_overrun();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        tests++;
        if (if_l.pout !== 8'h11 || if_m.pout !== 8'h88 || if_l.overrun !== 1'b1 || if_l.pout_valid !== 1'b1) begin
            fails++; $display("FAIL overrun_hold: got %h %h ovr=%b v=%b expected 11 88 1 1", if_l.pout, if_m.pout, if_l.overrun, if_l.pout_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (if_l.pout_valid !== 1'b0 || if_l.overrun !== 1'b1) begin
            fails++; $display("FAIL overrun_drain: got v=%b ovr=%b expected 0 1", if_l.pout_valid, if_l.overrun);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (if_l.overrun !== 1'b0 || if_m.overrun !== 1'b0) begin
            fails++; $display("FAIL overrun_clear: got %b/%b expected 0/0", if_l.overrun, if_m.overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w = 8'h22;
        send_word(8'h11, 1'b0);
        for (int i = 0; i < 7; i++) cycle(w[i], 1'b1, 1'b0, 1'b0);
        cycle(w[7], 1'b1, 1'b0, 1'b1);
        tests++;
        if (if_l.pout !== 8'h22 || if_l.pout_valid !== 1'b1 || if_l.overrun !== 1'b0) begin
            fails++; $display("FAIL back_to_back: got %h v=%b ovr=%b expected 22 1 0", if_l.pout, if_l.pout_valid, if_l.overrun);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (if_l.pout_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_drain: got v=%b expected 0", if_l.pout_valid);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (if_l.bit_cnt !== 3'd0) begin
            fails++; $display("FAIL clear_cnt: got %0d expected 0", if_l.bit_cnt);
        end
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if (if_l.bit_cnt !== 3'd0 || if_l.pout_valid !== 1'b0) begin
            fails++; $display("FAIL clear_with_en: got cnt=%0d v=%b expected 0 0", if_l.bit_cnt, if_l.pout_valid);
        end
        send_word(8'h5A, 1'b1);
        tests++;
        if (if_l.pout !== 8'h5A || if_m.pout !== 8'h5A || if_l.pout_valid !== 1'b1) begin
            fails++; $display("FAIL clear_then_5a: got %h/%h v=%b expected 5a/5a 1", if_l.pout, if_m.pout, if_l.pout_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        send_word(8'hE7, 1'b0);
        send_word(8'h42, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({if_l.pout, if_l.pout_valid, if_l.bit_cnt, if_l.overrun} !== 13'h0 ||
            {if_m.pout, if_m.pout_valid, if_m.bit_cnt, if_m.overrun} !== 13'h0) begin
            fails++; $display("FAIL async_reset: got %h/%h expected 0/0",
                {if_l.pout, if_l.pout_valid, if_l.bit_cnt, if_l.overrun},
                {if_m.pout, if_m.pout_valid, if_m.bit_cnt, if_m.overrun});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hC3, 1'b0);
        tests++;
        if (if_l.pout !== 8'hC3 || if_m.pout !== 8'hC3 || if_l.pout_valid !== 1'b1 || if_l.overrun !== 1'b0) begin
            fails++; $display("FAIL post_reset_word: got %h/%h v=%b ovr=%b expected c3/c3 1 0", if_l.pout, if_m.pout, if_l.pout_valid, if_l.overrun);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)));
            tests++;
            if (if_l.pout !== m_pout_l || if_m.pout !== m_pout_m ||
                if_l.pout_valid !== m_valid || if_m.pout_valid !== m_valid ||
                if_l.overrun !== m_ovr || if_m.overrun !== m_ovr ||
                if_l.bit_cnt !== 3'(bq.size()) || if_m.bit_cnt !== 3'(bq.size())) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_cycle_%0d: got l=%h m=%h v=%b/%b ovr=%b/%b cnt=%0d/%0d expected l=%h m=%h v=%b ovr=%b cnt=%0d",
                        n, if_l.pout, if_m.pout, if_l.pout_valid, if_m.pout_valid, if_l.overrun, if_m.overrun,
                        if_l.bit_cnt, if_m.bit_cnt, m_pout_l, m_pout_m, m_valid, m_ovr, bq.size());
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic_word();
        test_bit_order();
        test_en_gaps();
        test_overrun();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
